// File: rtl/reg_file_pkg.sv
// Shared constants and types for the integer register file.
// Optional macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
package reg_file_pkg;

    localparam int REG_SIZE_D   = 32;
    localparam int NO_OF_REGS_D = 32;
    localparam int REGW_D       = $clog2(REG_SIZE_D);
    localparam int ZERO_REG     = 0;

    typedef logic [REG_SIZE_D-1:0] reg_data_t;
    typedef logic [REGW_D-1:0]     reg_addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Bus bundle between decode/writeback and the register file.
// Optional macro: REG_FILE_BYPASS_EN (no signals depend on it).
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int REG_SIZE = REG_SIZE_D,
    parameter int REGW     = $clog2(REG_SIZE)
);

    logic [REGW-1:0]     raddr1_i;
    logic [REG_SIZE-1:0] rdata1_o;
    logic [REGW-1:0]     raddr2_i;
    logic [REG_SIZE-1:0] rdata2_o;
    logic [REGW-1:0]     waddr_i;
    logic [REG_SIZE-1:0] wdata_i;

    modport master (
        output raddr1_i, raddr2_i, waddr_i, wdata_i,
        input  rdata1_o, rdata2_o
    );

    modport slave (
        input  raddr1_i, raddr2_i, waddr_i, wdata_i,
        output rdata1_o, rdata2_o
    );

endinterface

// File: rtl/reg_file_rport.sv
// Combinational read port: zero register, out-of-range and bypass mux.
// Optional macro: REG_FILE_BYPASS_EN adds same-cycle write forwarding.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int REG_SIZE   = REG_SIZE_D,
    parameter int NO_OF_REGS = NO_OF_REGS_D,
    parameter int REGW       = $clog2(REG_SIZE)
) (
    input  logic [REG_SIZE-1:0] regs_i [NO_OF_REGS],
    input  logic [REGW-1:0]     raddr_i,
`ifdef REG_FILE_BYPASS_EN
    input  logic                rst_i,
    input  logic [REGW-1:0]     waddr_i,
    input  logic [REG_SIZE-1:0] wdata_i,
`endif
    output logic [REG_SIZE-1:0] rdata_o
);

    logic rd_ok;
    assign rd_ok = (raddr_i != REGW'(ZERO_REG))
                && (32'(raddr_i) < NO_OF_REGS);

`ifdef REG_FILE_BYPASS_EN
    logic byp;
    assign byp = !rst_i
              && (raddr_i == waddr_i)
              && (waddr_i != REGW'(ZERO_REG))
              && (32'(waddr_i) < NO_OF_REGS);
`endif

    // Select array entry, forced zero for x0 and unmapped indices
    always_comb begin
        rdata_o = '0;
        if (rd_ok)
            rdata_o = regs_i[raddr_i];
`ifdef REG_FILE_BYPASS_EN
        if (byp)
            rdata_o = wdata_i;
`endif
    end

endmodule

// File: rtl/reg_file.sv
// Integer register file: 2 async read ports, 1 sync write port, x0 = 0.
// Optional macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_SIZE   = REG_SIZE_D,
    parameter int NO_OF_REGS = NO_OF_REGS_D,
    parameter int REGW       = $clog2(REG_SIZE)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    reg_file_if.slave  bus
);

    logic [REG_SIZE-1:0] reg_file [NO_OF_REGS];

    logic wr_known;
    logic wr_en;

`ifdef SYNTHESIS
    assign wr_known = 1'b1;
`else
    // An unknown index must not corrupt any entry in simulation
    assign wr_known = !$isunknown(bus.waddr_i);
`endif

    assign wr_en = wr_known
                && (bus.waddr_i != REGW'(ZERO_REG))
                && (32'(bus.waddr_i) < NO_OF_REGS);

    // Storage: async clear, otherwise write every edge (no enable)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NO_OF_REGS; i++)
                reg_file[i] <= '0;
        end else if (wr_en) begin
            reg_file[bus.waddr_i] <= bus.wdata_i;
        end
    end

    reg_file_rport #(
        .REG_SIZE  (REG_SIZE),
        .NO_OF_REGS(NO_OF_REGS),
        .REGW      (REGW)
    ) u_rport1 (
        .regs_i  (reg_file),
        .raddr_i (bus.raddr1_i),
`ifdef REG_FILE_BYPASS_EN
        .rst_i   (rst_i),
        .waddr_i (bus.waddr_i),
        .wdata_i (bus.wdata_i),
`endif
        .rdata_o (bus.rdata1_o)
    );

    reg_file_rport #(
        .REG_SIZE  (REG_SIZE),
        .NO_OF_REGS(NO_OF_REGS),
        .REGW      (REGW)
    ) u_rport2 (
        .regs_i  (reg_file),
        .raddr_i (bus.raddr2_i),
`ifdef REG_FILE_BYPASS_EN
        .rst_i   (rst_i),
        .waddr_i (bus.waddr_i),
        .wdata_i (bus.wdata_i),
`endif
        .rdata_o (bus.rdata2_o)
    );

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed steps plus random traffic vs a model.
// Follows REG_FILE_BYPASS_EN to pick the expected read behaviour.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] model [32];

    reg_file_if bus ();

    reg_file dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural view of a read given current bus inputs
    function automatic logic [31:0] mread(input logic [4:0] ra);
        logic [31:0] v;
        v = (ra == 5'd0) ? 32'd0 : model[ra];
`ifdef REG_FILE_BYPASS_EN
        if (!rst && ra == bus.waddr_i && bus.waddr_i != 5'd0)
            v = bus.wdata_i;
`endif
        return v;
    endfunction

    task automatic step(input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        bus.waddr_i  = wa;
        bus.wdata_i  = wd;
        bus.raddr1_i = r1;
        bus.raddr2_i = r2;
        #1;
        chk("pre_rd1", bus.rdata1_o, mread(r1));
        chk("pre_rd2", bus.rdata2_o, mread(r2));
        @(posedge clk);
        if (!rst && wa != 5'd0)
            model[wa] = wd;
        #1;
        chk("post_rd1", bus.rdata1_o, mread(r1));
        chk("post_rd2", bus.rdata2_o, mread(r2));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++)
            model[i] = 32'd0;
    endtask

    initial begin
        clear_model();
        bus.waddr_i  = '0;
        bus.wdata_i  = '0;
        bus.raddr1_i = '0;
        bus.raddr2_i = '0;
        rst = 1'b1;
        #1;
        chk("rst_arr1", dut.reg_file[1], 32'd0);
        chk("rst_rd1", bus.rdata1_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First writes
        step(5'd1, 32'd5, 5'd1, 5'd2);
        step(5'd2, 32'd8, 5'd1, 5'd2);
        chk("wr_arr1", dut.reg_file[1], 32'd5);
        chk("wr_arr2", dut.reg_file[2], 32'd8);

        // Async reset pulse
        @(negedge clk);
        bus.waddr_i = 5'd0;
        rst = 1'b1;
        #1;
        clear_model();
        chk("arst_arr1", dut.reg_file[1], 32'd0);
        chk("arst_arr2", dut.reg_file[2], 32'd0);
        chk("arst_rd1", bus.rdata1_o, 32'd0);
        chk("arst_rd2", bus.rdata2_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Post-reset writes and reads
        step(5'd3, 32'd19, 5'd1, 5'd2);
        step(5'd4, 32'd20, 5'd1, 5'd2);
        chk("pr_rd1_0", bus.rdata1_o, 32'd0);
        chk("pr_rd2_0", bus.rdata2_o, 32'd0);
        step(5'd0, 32'd0, 5'd3, 5'd4);
        chk("pr_rd1_19", bus.rdata1_o, 32'd19);
        chk("pr_rd2_20", bus.rdata2_o, 32'd20);

        // Zero register ignores writes
        step(5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        chk("x0_rd1", bus.rdata1_o, 32'd0);
        chk("x0_arr", dut.reg_file[0], 32'd0);

        // Both ports on the same index
        step(5'd0, 32'd0, 5'd3, 5'd3);
        chk("dual_rd1", bus.rdata1_o, 32'd19);
        chk("dual_rd2", bus.rdata2_o, 32'd19);

        // Read during write to same index
        @(negedge clk);
        bus.waddr_i  = 5'd5;
        bus.wdata_i  = 32'd7;
        bus.raddr1_i = 5'd5;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("byp_pre", bus.rdata1_o, 32'd7);
`else
        chk("byp_pre", bus.rdata1_o, 32'd0);
`endif
        @(posedge clk);
        model[5] = 32'd7;
        #1;
        chk("byp_post", bus.rdata1_o, 32'd7);

        // Reset overrides a same-cycle write
        @(negedge clk);
        bus.waddr_i = 5'd6;
        bus.wdata_i = 32'hAAAA5555;
        rst = 1'b1;
        #1;
        clear_model();
        chk("rstw_rd1", bus.rdata1_o, 32'd0);
        @(posedge clk);
        #1;
        chk("rstw_arr6", dut.reg_file[6], 32'd0);
        @(negedge clk);
        bus.waddr_i = 5'd0;
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            step(5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Final full-array comparison
        @(negedge clk);
        bus.waddr_i = 5'd0;
        for (int i = 0; i < 32; i++)
            chk($sformatf("arr%0d", i), dut.reg_file[i], model[i]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose integer register file for the single-cycle RISC-V core.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between the decode stage (source and destination register indices) and the ALU and writeback paths.

Parameters:
- REG_SIZE, 32, data width of each register in bits.
- NO_OF_REGS, 32, number of architectural registers.
- REGW, $clog2(REG_SIZE) (=5), address width. Must satisfy 2**REGW >= NO_OF_REGS.

Ports:
- clk_i  input  1  system clock; rising edge active.
- rst_i  input  1  asynchronous, active-high reset.
- raddr1_i  input  REGW  read port 1 register index (rs1).
- rdata1_o  output  REG_SIZE  read port 1 data.
- raddr2_i  input  REGW  read port 2 register index (rs2).
- rdata2_o  output  REG_SIZE  read port 2 data.
- waddr_i  input  REGW  write port register index (rd).
- wdata_i  input  REG_SIZE  write port data.

Interface note: one clock (clk_i); reset rst_i is asynchronous and active-high.

Behaviour:
- Storage: internal array named reg_file, NO_OF_REGS entries of REG_SIZE bits. The array name is fixed; benches probe it hierarchically.
- Reset:
  - rst_i high clears every entry to 0 immediately, without waiting for a clock edge.
  - Entries stay 0 while rst_i is held high.
  - No writes occur while rst_i is high.
- Write:
  - There is no write-enable. On every rising clk_i with rst_i low, reg_file[waddr_i] <= wdata_i.
  - Writes to index 0 are discarded.
  - Writes to an index >= NO_OF_REGS are discarded.
  - A write is visible in the array after that edge (one-cycle latency).
- Read:
  - Purely combinational: rdataN_o = reg_file[raddrN_i].
  - Index 0 always reads 0.
  - An index >= NO_OF_REGS reads 0.
  - Both ports are independent and may address the same register.
- Read during write to the same index (macro absent): the read returns the old value until the clock edge, then the new value.
- Reset asserted mid-operation: it overrides a write occurring in the same cycle, and outputs read 0 combinationally.
- Unknown or X write address: do not update any entry. Guard with a known-value check in simulation only; synthesis treats it as a don't-care.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding on both read ports.
  - When rst_i is low, raddrN_i == waddr_i, and waddr_i != 0 and < NO_OF_REGS, rdataN_o = wdata_i in the same cycle.
  - Otherwise the normal array read applies.
- Undefined: no forwarding; reads return array contents only.

Decomposition:
- Shared package reg_file_pkg:
  - Default constants REG_SIZE_D=32, NO_OF_REGS_D=32.
  - ZERO_REG index constant (0).
  - typedefs reg_data_t (logic [REG_SIZE-1:0]) and reg_addr_t (logic [REGW-1:0]).
- One natural sub-module: reg_file_rport. It is a combinational read port with the zero-register, out-of-range and optional bypass mux, instantiated twice.
- Write logic and storage stay in reg_file.

Test Plan:
- Reset, then write checks:
  - Assert rst_i at t=0 and release at the first edge.
  - Drive waddr_i=1, wdata_i=5 for one edge, then waddr_i=2, wdata_i=8.
  - Required: reg_file[1]==5 and reg_file[2]==8 two edges later.
- Reset clearing: pulse rst_i for one cycle after the writes above -> reg_file[1] and reg_file[2] read 0 immediately on assertion, before any clock edge.
- Post-reset writes and reads:
  - Write 3<-19, then 4<-20.
  - Then raddr1_i=1 -> rdata1_o=0; raddr2_i=2 -> rdata2_o=0.
  - raddr1_i=3 -> 19; raddr2_i=4 -> 20.
- Zero register: write waddr_i=0, wdata_i=32'hDEADBEEF -> rdata1_o with raddr1_i=0 is 0, and reg_file[0]==0.
- Dual-port same index: raddr1_i=raddr2_i=3 after 3<-19 -> both outputs 19.
- Bypass:
  - With REG_FILE_BYPASS_EN: waddr_i=5, wdata_i=7, raddr1_i=5 before the edge -> rdata1_o=7 in the same cycle.
  - Without the macro: rdata1_o=0 before the edge and 7 after it.
